// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared ASCII constants and state encodings for the UART hex printer
package uart_pkg;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_X  = 8'h78;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PFX0 = 3'd1,
    S_PFX1 = 3'd2,
    S_HEX  = 3'd3,
    S_EOL0 = 3'd4,
    S_EOL1 = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // Optional states are skipped by jumping straight to the next one that exists.
  function automatic state_t after_idle(input int prefix_en);
    return (prefix_en != 0) ? S_PFX0 : S_HEX;
  endfunction

  function automatic state_t after_hex(input int eol);
    return (eol != 0) ? S_EOL0 : S_DONE;
  endfunction

  function automatic state_t after_eol0(input int eol);
    return (eol == 2) ? S_EOL1 : S_DONE;
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// rtl/hex_nibble_ascii.sv - combinational nibble to upper-case ASCII hex digit
module hex_nibble_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = 8'h00;
    if (nib_i < 4'd10) ascii_o = ASC_0 + {4'h0, nib_i};
    else               ascii_o = ASC_A + {4'h0, nib_i} - 8'd10;
  end

endmodule

// File: rtl/uart_hex_tx.sv
// rtl/uart_hex_tx.sv - prints one word as "0x"-prefixed upper-case hex text into a TX FIFO write port
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PREFIX_EN = 1,
  parameter int EOL       = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              wr_en_o,
  output logic [7:0]        dout_o,
  input  logic              full_i,
  output logic              done_o
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = $clog2(NIB + 1);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ready_q, done_q;
  logic                emit;
  logic [7:0]          hex_char;

  hex_nibble_ascii u_nib (
    .nib_i   (shreg_q[DATA_W-1 -: 4]),
    .ascii_o (hex_char)
  );

  assign emit    = (state_q == S_PFX0) || (state_q == S_PFX1) || (state_q == S_HEX) ||
                   (state_q == S_EOL0) || (state_q == S_EOL1);
  assign wr_en_o = emit && !full_i;
  assign ready_o = ready_q;
  assign done_o  = done_q;

  always_comb begin
    dout_o = 8'h00;
    case (state_q)
      S_PFX0:  dout_o = ASC_0;
      S_PFX1:  dout_o = ASC_X;
      S_HEX:   dout_o = hex_char;
      S_EOL0:  dout_o = (EOL == 2) ? ASC_CR : ASC_LF;
      S_EOL1:  dout_o = ASC_LF;
      default: dout_o = 8'h00;
    endcase
  end

  // Emit states only move on a write, so a full FIFO simply freezes the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = after_idle(PREFIX_EN);
      S_PFX0:  if (wr_en_o) state_d = S_PFX1;
      S_PFX1:  if (wr_en_o) state_d = S_HEX;
      S_HEX:   if (wr_en_o && cnt_q == LAST_NIB) state_d = after_hex(EOL);
      S_EOL0:  if (wr_en_o) state_d = after_eol0(EOL);
      S_EOL1:  if (wr_en_o) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      done_q  <= (state_d == S_DONE);
      if (state_q == S_IDLE && start_i) begin
        shreg_q <= data_i;
        cnt_q   <= '0;
      end else if (state_q == S_HEX && wr_en_o) begin
        shreg_q <= shreg_q << 4;
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb/tb_uart_hex_tx.sv - directed self-checking bench for uart_hex_tx
module tb_uart_hex_tx;

  logic        clk = 1'b0;
  logic        rst_n, start, full;
  logic [31:0] data;
  logic        ready, wr_en, done;
  logic [7:0]  dout;

  logic        start8, full8;
  logic [7:0]  data8;
  logic        ready8, wr_en8, done8;
  logic [7:0]  dout8;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_hex_tx dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(data), .ready_o(ready),
    .wr_en_o(wr_en), .dout_o(dout), .full_i(full), .done_o(done)
  );

  uart_hex_tx #(.DATA_W(8), .PREFIX_EN(0), .EOL(0)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .data_i(data8), .ready_o(ready8),
    .wr_en_o(wr_en8), .dout_o(dout8), .full_i(full8), .done_o(done8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Caller is at a negedge; start is raised now, frame is followed to the ready cycle.
  task automatic run_frame(input string tag, input logic [31:0] d, input logic [31:0] d_late,
                           input int fst, input int flen, input int st1, input int st2,
                           input logic [7:0] exp [12]);
    int idx;
    bit fin;
    idx   = 0;
    fin   = 0;
    data  = d;
    start = 1'b1;
    full  = 1'b0;
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      @(negedge clk);
      start = (cyc == st1) || (cyc == st2);
      data  = d_late;
      full  = (cyc >= fst) && (cyc < fst + flen);
      #1;
      if (cyc <= 12 + flen) begin
        check({tag, " wr_en"}, wr_en, !full);
        if (idx < 12) check({tag, " dout"}, dout, exp[idx]);
        if (wr_en) idx++;
        check({tag, " busy ready"}, ready, 1'b0);
        check({tag, " early done"}, done, 1'b0);
      end else if (cyc == 12 + flen + 1) begin
        check({tag, " done"}, done, 1'b1);
        check({tag, " done ready"}, ready, 1'b0);
        check({tag, " done wr_en"}, wr_en, 1'b0);
        check({tag, " byte count"}, idx, 12);
      end else begin
        check({tag, " ready back"}, ready, 1'b1);
        check({tag, " done cleared"}, done, 1'b0);
        fin = 1;
      end
    end
    check({tag, " finished"}, fin, 1'b1);
    start = 1'b0;
    full  = 1'b0;
  endtask

  logic [7:0] e_dead [12];
  logic [7:0] e_zero [12];
  logic [7:0] e_000f [12];
  logic [7:0] e_cafe [12];

  initial begin
    e_dead = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    e_zero = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    e_000f = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h46, 8'h0D, 8'h0A};
    e_cafe = '{8'h30, 8'h78, 8'h43, 8'h41, 8'h46, 8'h45, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};

    rst_n = 1'b0; start = 1'b0; full = 1'b0; data = '0;
    start8 = 1'b0; full8 = 1'b0; data8 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst ready", ready, 1'b1);
    check("rst wr_en", wr_en, 1'b0);
    check("rst dout", dout, 8'h00);
    check("rst done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame("t1", 32'hDEADBEEF, 32'hDEADBEEF, 99, 0, 0, 0, e_dead);
    run_frame("t2", 32'hDEADBEEF, 32'h0, 5, 5, 0, 0, e_dead);
    run_frame("t2b", 32'hDEADBEEF, 32'h0, 1, 3, 0, 0, e_dead);
    run_frame("t3", 32'h0, 32'h12345678, 99, 0, 3, 7, e_zero);

    data = 32'hDEADBEEF;
    start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("t4 pending wr_en", wr_en, 1'b1);
    check("t4 pending dout", dout, 8'h44);
    rst_n = 1'b0;
    #1;
    check("t4 rst wr_en", wr_en, 1'b0);
    check("t4 rst ready", ready, 1'b1);
    check("t4 rst done", done, 1'b0);
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      check("t4 no done", done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("t4 no done after release", done, 1'b0);
    run_frame("t4", 32'h0000000F, 32'hFFFFFFFF, 99, 0, 0, 0, e_000f);

    data8  = 8'h0A;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    data8  = 8'hFF;
    #1;
    check("t5 c1 wr_en", wr_en8, 1'b1);
    check("t5 c1 dout", dout8, 8'h30);
    @(negedge clk);
    #1;
    check("t5 c2 wr_en", wr_en8, 1'b1);
    check("t5 c2 dout", dout8, 8'h41);
    @(negedge clk);
    #1;
    check("t5 c3 done", done8, 1'b1);
    check("t5 c3 wr_en", wr_en8, 1'b0);
    @(negedge clk);
    #1;
    check("t5 c4 ready", ready8, 1'b1);
    check("t5 c4 done", done8, 1'b0);

    run_frame("t6a", 32'hDEADBEEF, 32'h0, 99, 0, 0, 0, e_dead);
    run_frame("t6b", 32'hCAFE0123, 32'h0, 99, 0, 0, 0, e_cafe);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
